// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg
//   Shared types and constants for the multi-lane RGB-to-gray converter.
//   - gray_mode_e : runtime conversion mode carried with each beat
//   - coef16_t    : one R/G/B coefficient triple at 16 fraction bits
//   - COEF_*      : the BT.601, BT.709 and average coefficient triples
//   - scale_coef / scale_triple : rescale a 16-bit-fraction coefficient to an
//     arbitrary fraction width (round-to-nearest when narrowing)
package rgb2gray_pkg;

   typedef enum logic [1:0] {
      BT601 = 2'd0,
      BT709 = 2'd1,
      AVG   = 2'd2,
      MAX   = 2'd3
   } gray_mode_e;

   typedef struct packed {
      logic [15:0] r;
      logic [15:0] g;
      logic [15:0] b;
   } coef16_t;

   // Rescaled triple; up to 32 fraction bits are supported.
   typedef struct packed {
      logic [31:0] r;
      logic [31:0] g;
      logic [31:0] b;
   } coef32_t;

   localparam int unsigned COEF_FRAC_BITS = 16;

   localparam coef16_t COEF_BT601 = '{r: 16'd19595, g: 16'd38470, b: 16'd7471};
   localparam coef16_t COEF_BT709 = '{r: 16'd13933, g: 16'd46871, b: 16'd4732};
   localparam coef16_t COEF_AVG   = '{r: 16'd21845, g: 16'd21845, b: 16'd21845};

   function automatic logic [31:0] scale_coef(input logic [15:0] c16,
                                              input int unsigned cw);
      logic [47:0] t;
      t = {32'd0, c16};
      if (cw >= COEF_FRAC_BITS) begin
         t = t << (cw - COEF_FRAC_BITS);
      end else begin
         t = (t + (48'd1 << (COEF_FRAC_BITS - 1 - cw))) >> (COEF_FRAC_BITS - cw);
      end
      return 32'(t);
   endfunction

   function automatic coef32_t scale_triple(input coef16_t c, input int unsigned cw);
      coef32_t s;
      s.r = scale_coef(c.r, cw);
      s.g = scale_coef(c.g, cw);
      s.b = scale_coef(c.b, cw);
      return s;
   endfunction

endpackage

// File: rtl/rgb2gray_if.sv
// rgb2gray_if
//   Pixel-in / gray-out stream bundle for rgb2gray_pipe.
//   Input side : valid_i, red_i, green_i, blue_i, mode_i, last_i -> ready_o
//   Output side: valid_o, gray_o, last_o                          <- ready_i
//   Lane k of every packed bus sits at [k*width_p +: width_p].
//   slave  : converter view
//   master : source/sink view (pixel source and gray consumer)
interface rgb2gray_if #(
   parameter int unsigned width_p = 8,
   parameter int unsigned lanes_p = 1
);
   logic                         valid_i;
   logic [lanes_p*width_p-1:0]   red_i;
   logic [lanes_p*width_p-1:0]   green_i;
   logic [lanes_p*width_p-1:0]   blue_i;
   logic [1:0]                   mode_i;
   logic                         last_i;
   logic                         ready_o;

   logic                         valid_o;
   logic [lanes_p*width_p-1:0]   gray_o;
   logic                         last_o;
   logic                         ready_i;

   modport slave (
      input  valid_i, red_i, green_i, blue_i, mode_i, last_i, ready_i,
      output ready_o, valid_o, gray_o, last_o
   );

   modport master (
      output valid_i, red_i, green_i, blue_i, mode_i, last_i, ready_i,
      input  ready_o, valid_o, gray_o, last_o
   );
endinterface

// File: rtl/rgb2gray_lane.sv
// rgb2gray_lane
//   One pixel lane of the two-stage converter datapath.
//   Stage 1: per-channel products (or, in MAX mode, the channel maximum
//            placed in the red product slot).
//   Stage 2: sum, round-to-nearest, saturate to width_p bits.
//   Ports:
//     i_clk, i_rst     clock, async active-high reset
//     i_ld1, i_ld2     stage load enables from the shared control
//     i_mode           mode of the beat entering stage 1
//     i_mode_s1        mode of the beat held in stage 1
//     i_red/green/blue lane input pixel
//     o_gray           registered gray result (stage 2)
module rgb2gray_lane
   import rgb2gray_pkg::*;
#(
   parameter int unsigned width_p      = 8,
   parameter int unsigned coef_width_p = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_ld1,
   input  logic               i_ld2,
   input  gray_mode_e         i_mode,
   input  gray_mode_e         i_mode_s1,
   input  logic [width_p-1:0] i_red,
   input  logic [width_p-1:0] i_green,
   input  logic [width_p-1:0] i_blue,
   output logic [width_p-1:0] o_gray
);

   localparam int unsigned PW = width_p + coef_width_p;
   localparam int unsigned SW = PW + 2;
   localparam int unsigned GW = SW - coef_width_p;

   localparam coef32_t C601 = scale_triple(COEF_BT601, coef_width_p);
   localparam coef32_t C709 = scale_triple(COEF_BT709, coef_width_p);
   localparam coef32_t CAVG = scale_triple(COEF_AVG, coef_width_p);

   localparam logic [SW-1:0] RND  = {{(SW-1){1'b0}}, 1'b1} << (coef_width_p - 1);
   localparam logic [GW-1:0] GMAX = {2'b00, {width_p{1'b1}}};

   logic [coef_width_p-1:0] w_cr;
   logic [coef_width_p-1:0] w_cg;
   logic [coef_width_p-1:0] w_cb;
   logic [PW-1:0]           w_prod_r;
   logic [PW-1:0]           w_prod_g;
   logic [PW-1:0]           w_prod_b;
   logic [width_p-1:0]      w_max;
   logic [SW-1:0]           w_sum;
   logic [GW-1:0]           w_shift;
   logic [width_p-1:0]      w_gray;

   logic [PW-1:0]           r_pr;
   logic [PW-1:0]           r_pg;
   logic [PW-1:0]           r_pb;
   logic [width_p-1:0]      r_gray;

   always_comb begin
      w_cr = '0;
      w_cg = '0;
      w_cb = '0;
      case (i_mode)
         BT601: begin
            w_cr = coef_width_p'(C601.r);
            w_cg = coef_width_p'(C601.g);
            w_cb = coef_width_p'(C601.b);
         end
         BT709: begin
            w_cr = coef_width_p'(C709.r);
            w_cg = coef_width_p'(C709.g);
            w_cb = coef_width_p'(C709.b);
         end
         AVG: begin
            w_cr = coef_width_p'(CAVG.r);
            w_cg = coef_width_p'(CAVG.g);
            w_cb = coef_width_p'(CAVG.b);
         end
         default: ;
      endcase
   end

   assign w_prod_r = PW'(i_red)   * PW'(w_cr);
   assign w_prod_g = PW'(i_green) * PW'(w_cg);
   assign w_prod_b = PW'(i_blue)  * PW'(w_cb);

   always_comb begin
      w_max = i_red;
      if (i_green > w_max) w_max = i_green;
      if (i_blue > w_max)  w_max = i_blue;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pr <= '0;
         r_pg <= '0;
         r_pb <= '0;
      end else if (i_ld1) begin
         if (i_mode == MAX) begin
            r_pr <= PW'(w_max);
            r_pg <= '0;
            r_pb <= '0;
         end else begin
            r_pr <= w_prod_r;
            r_pg <= w_prod_g;
            r_pb <= w_prod_b;
         end
      end
   end

   assign w_sum   = SW'(r_pr) + SW'(r_pg) + SW'(r_pb) + RND;
   assign w_shift = GW'(w_sum >> coef_width_p);

   always_comb begin
      if (i_mode_s1 == MAX) begin
         w_gray = r_pr[width_p-1:0];
      end else if (w_shift > GMAX) begin
         w_gray = '1;
      end else begin
         w_gray = w_shift[width_p-1:0];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_gray <= '0;
      end else if (i_ld2) begin
         r_gray <= w_gray;
      end
   end

   assign o_gray = r_gray;

endmodule

// File: rtl/rgb2gray_pipe.sv
// rgb2gray_pipe
//   Multi-lane RGB-to-gray converter with a two-stage elastic pipeline,
//   full valid/ready backpressure and a last sideband.
//   Ports:
//     clk_i    clock
//     reset_i  async active-high reset (deassertion synchronised upstream)
//     bus      rgb2gray_if.slave: pixel input stream and gray output stream
//   Latency 2 cycles, throughput 1 beat/cycle. ready_o is a combinational
//   function of ready_i; there is no skid buffer.
module rgb2gray_pipe
   import rgb2gray_pkg::*;
#(
   parameter int unsigned width_p      = 8,
   parameter int unsigned lanes_p      = 1,
   parameter int unsigned coef_width_p = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   rgb2gray_if.slave   bus
);

   logic                       w_ready_s1;
   logic                       w_ready_s2;
   logic                       w_ld1;
   logic                       w_ld2;
   gray_mode_e                 w_mode_in;
   logic [lanes_p*width_p-1:0] w_gray;

   logic                       r_v1;
   logic                       r_v2;
   logic                       r_last1;
   logic                       r_last2;
   gray_mode_e                 r_mode1;

   // A stage accepts when it is empty or its contents leave this edge.
   assign w_ready_s2 = ~r_v2 | bus.ready_i;
   assign w_ready_s1 = ~r_v1 | w_ready_s2;
   assign w_ld1      = bus.valid_i & w_ready_s1;
   assign w_ld2      = r_v1 & w_ready_s2;
   assign w_mode_in  = gray_mode_e'(bus.mode_i);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_last1 <= 1'b0;
         r_last2 <= 1'b0;
         r_mode1 <= BT601;
      end else begin
         if (w_ready_s1) begin
            r_v1 <= bus.valid_i;
         end
         if (w_ld1) begin
            r_last1 <= bus.last_i;
            r_mode1 <= w_mode_in;
         end
         if (w_ready_s2) begin
            r_v2 <= r_v1;
         end
         if (w_ld2) begin
            r_last2 <= r_last1;
         end
      end
   end

   for (genvar k = 0; k < lanes_p; k++) begin : g_lane
      rgb2gray_lane #(
         .width_p      (width_p),
         .coef_width_p (coef_width_p)
      ) u_lane (
         .i_clk     (clk_i),
         .i_rst     (reset_i),
         .i_ld1     (w_ld1),
         .i_ld2     (w_ld2),
         .i_mode    (w_mode_in),
         .i_mode_s1 (r_mode1),
         .i_red     (bus.red_i[k*width_p +: width_p]),
         .i_green   (bus.green_i[k*width_p +: width_p]),
         .i_blue    (bus.blue_i[k*width_p +: width_p]),
         .o_gray    (w_gray[k*width_p +: width_p])
      );
   end

   assign bus.ready_o = w_ready_s1;
   assign bus.valid_o = r_v2;
   assign bus.last_o  = r_last2;
   assign bus.gray_o  = w_gray;

endmodule
